// File: rtl/core_pkg.sv
// Shared definitions for the vector instruction dispatch path: destination
// indices and masks, default sizing, and the opcode-to-destination lookup.
`timescale 1ns/1ps
package core_pkg;

   localparam int unsigned DefNrDst        = 3;
   localparam int unsigned DefQueueDepth   = 2;
   localparam int unsigned DefPayloadWidth = 64;

   typedef logic [$clog2(DefNrDst)-1:0]   dst_idx_t;
   typedef logic [$clog2(DefNrDst+1)-1:0] dst_cnt_t;
   typedef logic [DefNrDst-1:0]           dst_mask_t;

   localparam dst_idx_t DstAlu   = dst_idx_t'(0);
   localparam dst_idx_t DstMfpu  = dst_idx_t'(1);
   localparam dst_idx_t DstOpReq = dst_idx_t'(2);

   typedef enum logic [2:0] {
      VOP_ADD,
      VOP_MUL,
      VOP_FMA,
      VOP_LOAD,
      VOP_STORE,
      VOP_MOVE
   } vop_e;

   // Executing unit from the opcode; the operand requester joins whenever
   // vector sources must be read (stores always read their data register).
   function automatic dst_mask_t vop_dst_mask(input vop_e vop, input logic use_vs);
      dst_mask_t mask;
      mask = '0;
      case (vop)
         VOP_ADD, VOP_MOVE: mask[DstAlu]  = 1'b1;
         VOP_MUL, VOP_FMA:  mask[DstMfpu] = 1'b1;
         default:           mask         = '0;
      endcase
      if (use_vs || vop == VOP_STORE) mask[DstOpReq] = 1'b1;
      return mask;
   endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// Single-destination queue: fixed depth (any value >= 1), synchronous flush,
// head entry always presented on data_o. Storage is deliberately not reset.
`timescale 1ns/1ps
module dispatch_fifo #(
   parameter  int unsigned Depth = 2,
   parameter  int unsigned Width = 64,
   localparam int unsigned OccW  = $clog2(Depth + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [Width-1:0] data_i,
   output logic [Width-1:0] data_o,
   output logic [OccW-1:0]  occ_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned     PtrW     = (Depth > 1) ? $clog2(Depth) : 1;
   localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
   localparam logic [OccW-1:0] DepthOcc = OccW'(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  rptr_q, rptr_d, wptr_q, wptr_d;
   logic [OccW-1:0]  occ_q, occ_d;
   logic             push_en, pop_en;

   // Guards keep occupancy within [0, Depth] even if a caller misbehaves.
   assign push_en = push_i && (occ_q != DepthOcc) && !flush_i;
   assign pop_en  = pop_i && (occ_q != '0) && !flush_i;

   // Next pointers/occupancy; wrap by compare-and-clear so odd depths work.
   always_comb begin
      rptr_d = rptr_q;
      wptr_d = wptr_q;
      occ_d  = occ_q;
      if (flush_i) begin
         rptr_d = '0;
         wptr_d = '0;
         occ_d  = '0;
      end else begin
         if (pop_en)  rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
         if (push_en) wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
         if (push_en && !pop_en)      occ_d = occ_q + 1'b1;
         else if (!push_en && pop_en) occ_d = occ_q - 1'b1;
      end
   end

   // Pointer and occupancy registers, cleared asynchronously.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rptr_q <= '0;
         wptr_q <= '0;
         occ_q  <= '0;
      end else begin
         rptr_q <= rptr_d;
         wptr_q <= wptr_d;
         occ_q  <= occ_d;
      end
   end

   // Payload storage written at the tail on every accepted push.
   always_ff @(posedge clk_i) begin
      if (push_en) mem_q[wptr_q] <= data_i;
   end

   assign data_o  = mem_q[rptr_q];
   assign occ_o   = occ_q;
   assign full_o  = (occ_q == DepthOcc);
   assign empty_o = (occ_q == '0);

   // Occupancy never exceeds the depth.
   assert property (@(posedge clk_i) disable iff (!rst_ni) occ_q <= DepthOcc);
   // From empty, occupancy can only stay at zero or grow by one (no wrap-under).
   assert property (@(posedge clk_i) disable iff (!rst_ni)
                    (occ_q == '0) |-> (occ_d <= OccW'(1)));

endmodule

// File: rtl/vinsn_dispatcher.sv
// Fans each accepted request out to every destination in its mask, one
// queue per destination. Handshake: a request is taken when req_valid_i and
// req_ready_o are both high; ready is computed from mask, flush and the
// registered queue state only, so it never depends on req_valid_i or on any
// dst_ready_i. Each destination pops when dst_valid_o[d] && dst_ready_i[d].
`timescale 1ns/1ps
module vinsn_dispatcher
   import core_pkg::*;
#(
   parameter  int unsigned NrDst        = DefNrDst,
   parameter  int unsigned QueueDepth   = DefQueueDepth,
   parameter  int unsigned PayloadWidth = DefPayloadWidth,
   localparam int unsigned OccW         = $clog2(QueueDepth + 1)
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          req_valid_i,
   output logic                          req_ready_o,
   input  logic [PayloadWidth-1:0]       req_payload_i,
   input  logic [NrDst-1:0]              req_dst_mask_i,
   output logic [NrDst-1:0]              dst_valid_o,
   input  logic [NrDst-1:0]              dst_ready_i,
   output logic [NrDst*PayloadWidth-1:0] dst_payload_o,
   input  logic                          flush_i,
   output logic [NrDst*OccW-1:0]         occupancy_o,
   output logic                          idle_o
);

   logic [NrDst-1:0] full;
   logic [NrDst-1:0] empty;
   logic [NrDst-1:0] push;
   logic             accept;

   // All-or-nothing: refuse unless every targeted queue has a free slot now.
   always_comb begin
      req_ready_o = !flush_i;
      for (int unsigned d = 0; d < NrDst; d++) begin
         if (req_dst_mask_i[d] && full[d]) req_ready_o = 1'b0;
      end
   end

   assign accept = req_valid_i && req_ready_o;
   assign push   = {NrDst{accept}} & req_dst_mask_i;
   assign idle_o = &empty;

   for (genvar d = 0; d < NrDst; d++) begin : gen_dst
      dispatch_fifo #(
         .Depth (QueueDepth),
         .Width (PayloadWidth)
      ) i_fifo (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .push_i  (push[d]),
         .pop_i   (dst_valid_o[d] && dst_ready_i[d]),
         .flush_i (flush_i),
         .data_i  (req_payload_i),
         .data_o  (dst_payload_o[d*PayloadWidth +: PayloadWidth]),
         .occ_o   (occupancy_o[d*OccW +: OccW]),
         .full_o  (full[d]),
         .empty_o (empty[d])
      );
      assign dst_valid_o[d] = !empty[d];
   end

endmodule

// File: tb/tb_vinsn_dispatcher.sv
// Bench for vinsn_dispatcher: directed scenarios on a depth-2 instance and a
// long randomized run on a depth-3 instance against a per-destination queue model.
`timescale 1ns/1ps
module tb_vinsn_dispatcher;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // ---------------- DUT A: QueueDepth=2 ----------------
   logic         a_req_valid, a_req_ready, a_flush, a_idle;
   logic [63:0]  a_req_payload;
   logic [2:0]   a_mask, a_dst_valid, a_dst_ready;
   logic [191:0] a_dst_payload;
   logic [5:0]   a_occ;

   vinsn_dispatcher #(.NrDst(3), .QueueDepth(2), .PayloadWidth(64)) dut_a (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .req_valid_i    (a_req_valid),
      .req_ready_o    (a_req_ready),
      .req_payload_i  (a_req_payload),
      .req_dst_mask_i (a_mask),
      .dst_valid_o    (a_dst_valid),
      .dst_ready_i    (a_dst_ready),
      .dst_payload_o  (a_dst_payload),
      .flush_i        (a_flush),
      .occupancy_o    (a_occ),
      .idle_o         (a_idle)
   );

   // ---------------- DUT B: QueueDepth=3 ----------------
   logic         b_req_valid, b_req_ready, b_flush, b_idle;
   logic [63:0]  b_req_payload;
   logic [2:0]   b_mask, b_dst_valid, b_dst_ready;
   logic [191:0] b_dst_payload;
   logic [5:0]   b_occ;

   vinsn_dispatcher #(.NrDst(3), .QueueDepth(3), .PayloadWidth(64)) dut_b (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .req_valid_i    (b_req_valid),
      .req_ready_o    (b_req_ready),
      .req_payload_i  (b_req_payload),
      .req_dst_mask_i (b_mask),
      .dst_valid_o    (b_dst_valid),
      .dst_ready_i    (b_dst_ready),
      .dst_payload_o  (b_dst_payload),
      .flush_i        (b_flush),
      .occupancy_o    (b_occ),
      .idle_o         (b_idle)
   );

   // ---------------- scoreboard ----------------
   logic [63:0] exp_q [3][$];

   function automatic logic [63:0] a_pl(input int d);
      return a_dst_payload[d*64 +: 64];
   endfunction

   function automatic logic [1:0] a_oc(input int d);
      return a_occ[d*2 +: 2];
   endfunction

   // ---------------- driver tasks ----------------
   // Called just after a rising edge; applies inputs and lets logic settle.
   task automatic a_drive(input logic v, input logic [63:0] p, input logic [2:0] m,
                          input logic [2:0] r, input logic f);
      a_req_valid   = v;
      a_req_payload = p;
      a_mask        = m;
      a_dst_ready   = r;
      a_flush       = f;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst_n = 1'b0;
      b_req_valid = 0; b_req_payload = '0; b_mask = '0; b_dst_ready = '0; b_flush = 0;
      a_drive(0, 64'h0, 3'b111, 3'b000, 0);
      #2;
      checks++; if (a_req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b exp 1", a_req_ready); end
      checks++; if (a_dst_valid !== 3'b000) begin failures++; $display("FAIL reset_valid got %b exp 000", a_dst_valid); end
      checks++; if (a_occ !== 6'd0) begin failures++; $display("FAIL reset_occ got %h exp 0", a_occ); end
      checks++; if (a_idle !== 1'b1) begin failures++; $display("FAIL reset_idle got %b exp 1", a_idle); end
      checks++; if (b_idle !== 1'b1 || b_dst_valid !== 3'b000) begin failures++; $display("FAIL reset_b got idle=%b valid=%b exp 1/000", b_idle, b_dst_valid); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single;
      a_drive(1, 64'hA5, 3'b101, 3'b111, 0);
      checks++; if (a_req_ready !== 1'b1) begin failures++; $display("FAIL single_ready got %b exp 1", a_req_ready); end
      tick();
      a_drive(0, 64'h0, 3'b000, 3'b111, 0);
      checks++; if (a_dst_valid !== 3'b101) begin failures++; $display("FAIL single_valid got %b exp 101", a_dst_valid); end
      checks++; if (a_pl(0) !== 64'hA5) begin failures++; $display("FAIL single_pl0 got %h exp a5", a_pl(0)); end
      checks++; if (a_pl(2) !== 64'hA5) begin failures++; $display("FAIL single_pl2 got %h exp a5", a_pl(2)); end
      checks++; if (a_occ !== 6'b01_00_01) begin failures++; $display("FAIL single_occ got %b exp 010001", a_occ); end
      tick();
      checks++; if (a_dst_valid !== 3'b000) begin failures++; $display("FAIL single_drained got %b exp 000", a_dst_valid); end
      checks++; if (a_occ !== 6'd0 || a_idle !== 1'b1) begin failures++; $display("FAIL single_idle got occ=%h idle=%b exp 0/1", a_occ, a_idle); end
   endtask

   task automatic test_backpressure;
      a_drive(1, 64'h11, 3'b010, 3'b000, 0);
      checks++; if (a_req_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got %b exp 1", a_req_ready); end
      tick();
      a_drive(1, 64'h22, 3'b010, 3'b000, 0);
      checks++; if (a_req_ready !== 1'b1) begin failures++; $display("FAIL bp_ready2 got %b exp 1", a_req_ready); end
      tick();
      a_drive(1, 64'h33, 3'b010, 3'b000, 0);
      checks++; if (a_req_ready !== 1'b0) begin failures++; $display("FAIL bp_ready3 got %b exp 0", a_req_ready); end
      checks++; if (a_oc(1) !== 2'd2) begin failures++; $display("FAIL bp_occ_full got %0d exp 2", a_oc(1)); end
      tick();
      a_drive(1, 64'h33, 3'b010, 3'b010, 0);
      checks++; if (a_req_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_pop got %b exp 0", a_req_ready); end
      checks++; if (a_pl(1) !== 64'h11) begin failures++; $display("FAIL bp_head0 got %h exp 11", a_pl(1)); end
      tick();
      a_drive(1, 64'h33, 3'b010, 3'b010, 0);
      checks++; if (a_req_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after got %b exp 1", a_req_ready); end
      checks++; if (a_pl(1) !== 64'h22 || a_oc(1) !== 2'd1) begin failures++; $display("FAIL bp_head1 got %h/%0d exp 22/1", a_pl(1), a_oc(1)); end
      tick();
      a_drive(0, 64'h0, 3'b000, 3'b010, 0);
      checks++; if (a_pl(1) !== 64'h33 || a_oc(1) !== 2'd1) begin failures++; $display("FAIL bp_head2 got %h/%0d exp 33/1", a_pl(1), a_oc(1)); end
      tick();
      checks++; if (a_idle !== 1'b1) begin failures++; $display("FAIL bp_idle got %b exp 1", a_idle); end
   endtask

   task automatic test_no_hol;
      a_drive(1, 64'h1, 3'b001, 3'b000, 0); tick();
      a_drive(1, 64'h2, 3'b001, 3'b000, 0); tick();
      a_drive(1, 64'h77, 3'b101, 3'b100, 0);
      checks++; if (a_req_ready !== 1'b0) begin failures++; $display("FAIL hol_blocked got %b exp 0", a_req_ready); end
      tick();
      a_drive(1, 64'h88, 3'b100, 3'b100, 0);
      checks++; if (a_dst_valid[2] !== 1'b0) begin failures++; $display("FAIL hol_partial got %b exp 0", a_dst_valid[2]); end
      checks++; if (a_req_ready !== 1'b1) begin failures++; $display("FAIL hol_free got %b exp 1", a_req_ready); end
      tick();
      a_drive(0, 64'h0, 3'b000, 3'b100, 0);
      checks++; if (a_dst_valid !== 3'b101 || a_pl(2) !== 64'h88) begin failures++; $display("FAIL hol_deliver got %b/%h exp 101/88", a_dst_valid, a_pl(2)); end
      tick();
      checks++; if (a_dst_valid !== 3'b001) begin failures++; $display("FAIL hol_after got %b exp 001", a_dst_valid); end
   endtask

   task automatic test_full_pop;
      a_drive(1, 64'h99, 3'b001, 3'b001, 0);
      checks++; if (a_req_ready !== 1'b0 || a_oc(0) !== 2'd2) begin failures++; $display("FAIL fp_refuse got %b/%0d exp 0/2", a_req_ready, a_oc(0)); end
      checks++; if (a_pl(0) !== 64'h1) begin failures++; $display("FAIL fp_head got %h exp 1", a_pl(0)); end
      tick();
      a_drive(1, 64'h99, 3'b001, 3'b001, 0);
      checks++; if (a_req_ready !== 1'b1 || a_oc(0) !== 2'd1) begin failures++; $display("FAIL fp_accept got %b/%0d exp 1/1", a_req_ready, a_oc(0)); end
      checks++; if (a_pl(0) !== 64'h2) begin failures++; $display("FAIL fp_head2 got %h exp 2", a_pl(0)); end
      tick();
      a_drive(0, 64'h0, 3'b000, 3'b001, 0);
      checks++; if (a_pl(0) !== 64'h99 || a_oc(0) !== 2'd1) begin failures++; $display("FAIL fp_pushpop got %h/%0d exp 99/1", a_pl(0), a_oc(0)); end
      tick();
      checks++; if (a_idle !== 1'b1) begin failures++; $display("FAIL fp_idle got %b exp 1", a_idle); end
   endtask

   task automatic test_flush;
      a_drive(1, 64'hA, 3'b011, 3'b000, 0); tick();
      a_drive(1, 64'hB, 3'b001, 3'b000, 0); tick();
      a_drive(1, 64'hF0, 3'b100, 3'b000, 1);
      checks++; if (a_occ !== 6'b00_01_10) begin failures++; $display("FAIL fl_pre_occ got %b exp 000110", a_occ); end
      checks++; if (a_req_ready !== 1'b0) begin failures++; $display("FAIL fl_ready got %b exp 0", a_req_ready); end
      tick();
      a_drive(0, 64'h0, 3'b000, 3'b111, 0);
      checks++; if (a_dst_valid !== 3'b000 || a_occ !== 6'd0 || a_idle !== 1'b1) begin failures++; $display("FAIL fl_cleared got v=%b occ=%h idle=%b exp 000/0/1", a_dst_valid, a_occ, a_idle); end
      tick();
      checks++; if (a_dst_valid !== 3'b000) begin failures++; $display("FAIL fl_ghost got %b exp 000", a_dst_valid); end
   endtask

   task automatic test_reset_mid;
      a_drive(1, 64'h5A, 3'b111, 3'b000, 0); tick();
      a_drive(0, 64'h0, 3'b000, 3'b000, 0);
      checks++; if (a_dst_valid !== 3'b111) begin failures++; $display("FAIL rm_loaded got %b exp 111", a_dst_valid); end
      rst_n = 1'b0;
      #1;
      checks++; if (a_dst_valid !== 3'b000 || a_occ !== 6'd0 || a_idle !== 1'b1) begin failures++; $display("FAIL rm_async got v=%b occ=%h idle=%b exp 000/0/1", a_dst_valid, a_occ, a_idle); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++; if (a_dst_valid !== 3'b000) begin failures++; $display("FAIL rm_after got %b exp 000", a_dst_valid); end
   endtask

   task automatic test_random;
      logic        v, f, exp_ready;
      logic [2:0]  m, r;
      logic [63:0] p;
      for (int d = 0; d < 3; d++) exp_q[d].delete();
      for (int cyc = 0; cyc < 10000; cyc++) begin
         v = 1'($urandom_range(0, 1));
         m = 3'($urandom_range(0, 7));
         r = 3'($urandom_range(0, 7));
         f = ($urandom_range(0, 63) == 0);
         p = {$urandom, $urandom};
         if (cyc >= 9990) begin v = 0; r = 3'b111; f = 0; end
         b_req_valid = v; b_mask = m; b_dst_ready = r; b_flush = f; b_req_payload = p;
         #1;
         exp_ready = !f;
         for (int d = 0; d < 3; d++) if (m[d] && exp_q[d].size() >= 3) exp_ready = 0;
         checks++; if (b_req_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready cyc %0d got %b exp %b", cyc, b_req_ready, exp_ready); end
         for (int d = 0; d < 3; d++) begin
            checks++; if (b_dst_valid[d] !== (exp_q[d].size() != 0)) begin failures++; $display("FAIL rnd_valid cyc %0d dst %0d got %b exp %b", cyc, d, b_dst_valid[d], exp_q[d].size() != 0); end
            checks++; if (b_occ[d*2 +: 2] !== 2'(exp_q[d].size())) begin failures++; $display("FAIL rnd_occ cyc %0d dst %0d got %0d exp %0d", cyc, d, b_occ[d*2 +: 2], exp_q[d].size()); end
            if (exp_q[d].size() != 0) begin
               checks++; if (b_dst_payload[d*64 +: 64] !== exp_q[d][0]) begin failures++; $display("FAIL rnd_payload cyc %0d dst %0d got %h exp %h", cyc, d, b_dst_payload[d*64 +: 64], exp_q[d][0]); end
            end
         end
         checks++; if (b_idle !== (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0)) begin failures++; $display("FAIL rnd_idle cyc %0d got %b", cyc, b_idle); end
         if (f) begin
            for (int d = 0; d < 3; d++) exp_q[d].delete();
         end else begin
            for (int d = 0; d < 3; d++) if (r[d] && exp_q[d].size() != 0) void'(exp_q[d].pop_front());
            if (v && exp_ready) for (int d = 0; d < 3; d++) if (m[d]) exp_q[d].push_back(p);
         end
         tick();
      end
      checks++; if (b_idle !== 1'b1) begin failures++; $display("FAIL rnd_drain got %b exp 1", b_idle); end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_no_hol();
      test_full_pop();
      test_flush();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vinsn_dispatcher.md
Name: vinsn_dispatcher

Overview:
Parametrised successor to the single-slot launcher. It fans one accepted issue request out to any subset of NrDst downstream consumers, such as VFUs and the operand requester. Each destination has its own FIFO of depth QueueDepth, so a slow consumer does not stall the others until its queue fills. Every request is delivered exactly once to each destination in its mask, in issue order per destination. A flush empties all queues.

Parameters:
NrDst, 3, number of destinations (>=1)
QueueDepth, 2, entries per destination FIFO (>=1; non-power-of-2 allowed)
PayloadWidth, 64, bits per request payload

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  upstream request valid
req_ready_o  out  1  upstream ready
req_payload_i  in  PayloadWidth  request payload
req_dst_mask_i  in  NrDst  bit d set = deliver to destination d
dst_valid_o  out  NrDst  per-destination valid
dst_ready_i  in  NrDst  per-destination ready
dst_payload_o  out  NrDst*PayloadWidth  per-destination payload (packed, dst 0 in LSBs)
flush_i  in  1  discard all queued and incoming requests
occupancy_o  out  NrDst*$clog2(QueueDepth+1)  per-destination entry count
idle_o  out  1  all queues empty

Behaviour:
- Reset (asynchronous, active-low) values: all queues empty; dst_valid_o=0; occupancy_o=0; idle_o=1; req_ready_o=1. Payload storage is not reset.
- Space rule: destination d has space iff occ[d] < QueueDepth. A pop in the same cycle does not count, so there is no combinational path from dst_ready_i to req_ready_o.
- req_ready_o = !flush_i && AND over d of (!req_dst_mask_i[d] || space[d]). It may depend combinationally on req_dst_mask_i; it must not depend on req_valid_i.
- Accept = req_valid_i && req_ready_o. On accept, the payload is pushed into every masked FIFO in the same edge. No partial delivery, ever.
- Mask 0: the request is accepted (ready=1) and dropped, with no state change.
- Latency: an accepted request appears on dst_valid_o/dst_payload_o the cycle after acceptance. There is no bypass.
- Per destination: pop = dst_valid_o[d] && dst_ready_i[d]. dst_valid_o[d] = occ[d]!=0. dst_payload_o[d] is the head entry, and it stays stable while valid && !ready.
- Simultaneous push and pop on d: occ unchanged, head advances, tail writes. This is legal only when occ>0; with occ==0 there is no pop.
- Full with simultaneous pop: push is still refused that cycle (the space rule holds).
- Pointers wrap modulo QueueDepth, with explicit compare-and-clear for non-power-of-2 depths.
- occ width = $clog2(QueueDepth+1). occ never exceeds QueueDepth and never underflows. Assertions must cover both.
- flush_i: at the next edge every occ and pointer becomes 0, so dst_valid_o=0 in the following cycle. Pops and any push in the flush cycle are discarded. req_ready_o=0 during flush. dst_valid_o may still be high during the flush cycle itself; downstream treats a handshake in that cycle as void.
- idle_o = all occ==0 (registered-state derived).
- Reset mid-operation: all in-flight entries are lost immediately (asynchronously).

Decomposition:
- Shared package core_pkg: dst index/count typedefs; the default QueueDepth constant; a helper function mapping vop/use_vs to a dst mask (replaces the single-target lookup).
- Sub-module: dispatch_fifo, one per destination via a generate loop. Ports: push, pop, flush, data in/out, occ, full, empty. The top holds only the ready/accept logic and the packing.

Test Plan:
1. Reset, then mask=3'b101, payload=8'hA5, all dst_ready=1 -> A5 valid on dst0 and dst2 in the next cycle only; dst1 never valid; occupancy returns to 0 after 1 cycle.
2. NrDst=3, QueueDepth=2; dst1 ready=0; push 3 requests with mask=3'b010 (11,22,33) -> first two accepted, req_ready_o=0 for the third while occ[1]=2. Raise ready -> dst1 outputs 11, 22, 33 in order; the third is accepted the cycle after the first pop.
3. dst0 stalled full, dst2 free; request mask=3'b101 -> not accepted, dst2 receives nothing. Request mask=3'b100 -> accepted immediately; dst2 receives it (no head-of-line blocking on independent masks).
4. Full dst0 with dst_ready_i[0]=1 and push to dst0 in the same cycle -> push refused, pop succeeds, occ drops 2->1. Next cycle the push is accepted.
5. Queues holding 2,1,0 entries; assert flush_i with req_valid_i=1 -> req_ready_o=0. Next cycle all dst_valid_o=0, occupancy_o=0, idle_o=1. The flushed request never appears.
6. QueueDepth=3, random mask/ready for 10k cycles against a scoreboard -> every accepted request delivered exactly once per masked destination, in order. No occupancy overflow or underflow assertions fire.
